// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: round-robin arbitration of the ALU and LSU
// writeback requesters onto the single RF write port, plus a per-register busy
// scoreboard that the issue stage queries for RAW/WAW hazards.
module rf_wb_scheduler #(
    parameter  int unsigned XLEN  = 64,
    parameter  int unsigned NREGS = 32,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [2*AW-1:0]     req_rd,
    input  logic [2*XLEN-1:0]   req_data,
    output logic [1:0]          req_ready,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic [AW-1:0]       rs1,
    input  logic [AW-1:0]       rs2,
    output logic                rs1_busy,
    output logic                rs2_busy,
    input  logic                flush
);

    // last_grant_q holds the index of the most recently granted requester
    logic              last_grant_q, last_grant_d;
    logic [1:0]        grant;
    logic              hs;
    logic              win;
    logic [AW-1:0]     win_rd;
    logic [XLEN-1:0]   win_data;

    logic              rf_we_q, rf_we_d;
    logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    logic [NREGS-1:0]  busy_q, busy_d;
    logic              issue_set;

    // Round-robin grant: a lone requester always wins, a tie goes to the one not granted last
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = grant;
    assign hs        = |grant;
    assign win       = grant[1];
    assign win_rd    = win ? req_rd[2*AW-1:AW]       : req_rd[AW-1:0];
    assign win_data  = win ? req_data[2*XLEN-1:XLEN] : req_data[XLEN-1:0];

    // Next-state for arbitration history and the registered write port; x0 writes are swallowed
    always_comb begin
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (hs) begin
            last_grant_d = win;
            if (win_rd != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = win_rd;
                rf_wdata_d = win_data;
            end
        end
    end

    // Issue claim is accepted for x0 or for any register not already pending a writeback
    assign issue_ready = issue_valid & ((issue_rd == '0) | ~busy_q[issue_rd]);
    assign issue_set   = issue_ready & (issue_rd != '0);

    // Scoreboard update: clear on the committing write, set on issue (set wins), flush clears all
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Hazard query reflects scoreboard state before the current edge
    assign rs1_busy = (rs1 != '0) & busy_q[rs1];
    assign rs2_busy = (rs2 != '0) & busy_q[rs2];

    // State registers; async reset drops any pending write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: a vector table for arbitration and
// writeback, hand sequences for scoreboard, x0, flush and mid-write reset, and a
// queue of expected RF writes popped one cycle after each grant.
module tb_rf_wb_scheduler;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [2*AW-1:0]     req_rd;
    logic [2*XLEN-1:0]   req_data;
    logic [1:0]          req_ready;
    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [XLEN-1:0]     rf_wdata;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic [AW-1:0]       rs1;
    logic [AW-1:0]       rs2;
    logic                rs1_busy;
    logic                rs2_busy;
    logic                flush;

    rf_wb_scheduler #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      valid;
        logic [AW-1:0]   rd0;
        logic [AW-1:0]   rd1;
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic [1:0]      exp_ready;
    } vec_t;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    vec_t            vecs[$];
    wr_t             sbq[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [AW-1:0]   m_addr = '0;
    logic [XLEN-1:0] m_data = '0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
        req_valid = v;
        req_rd    = {r1, r0};
        req_data  = {d1, d0};
    endtask

    // One clock: check combinational outputs mid-cycle, queue the expected write, check it after the edge
    task automatic cycle(input string tag, input logic [1:0] er, input logic eir,
                         input logic eb1, input logic eb2);
        wr_t w;
        wr_t e;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] d;
        @(negedge clk);
        chk({tag, " req_ready"},   XLEN'(req_ready),   XLEN'(er));
        chk({tag, " issue_ready"}, XLEN'(issue_ready), XLEN'(eir));
        chk({tag, " rs1_busy"},    XLEN'(rs1_busy),    XLEN'(eb1));
        chk({tag, " rs2_busy"},    XLEN'(rs2_busy),    XLEN'(eb2));
        w.we   = 1'b0;
        w.addr = m_addr;
        w.data = m_data;
        if (er != 2'b00) begin
            rd = er[1] ? req_rd[2*AW-1:AW]       : req_rd[AW-1:0];
            d  = er[1] ? req_data[2*XLEN-1:XLEN] : req_data[XLEN-1:0];
            if (rd != '0) begin
                w.we   = 1'b1;
                w.addr = rd;
                w.data = d;
                m_addr = rd;
                m_data = d;
            end
        end
        sbq.push_back(w);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s scoreboard: queue empty", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, " rf_we"},    XLEN'(rf_we),    XLEN'(e.we));
            chk({tag, " rf_waddr"}, XLEN'(rf_waddr), XLEN'(e.addr));
            chk({tag, " rf_wdata"}, rf_wdata,        e.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;
        flush       = 1'b0;
        drive(2'b00, '0, '0, '0, '0);

        // Reset state
        #2;
        chk("reset rf_we",     XLEN'(rf_we),     '0);
        chk("reset rf_waddr",  XLEN'(rf_waddr),  '0);
        chk("reset rf_wdata",  rf_wdata,         '0);
        chk("reset req_ready", XLEN'(req_ready), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Arbitration / write-port vectors; last_grant starts as LSU so ALU wins the first tie
        vecs.push_back('{2'b01, 5'd5, 5'd0, 64'hDEAD, 64'h0,    2'b01});
        vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    2'b00});
        vecs.push_back('{2'b10, 5'd0, 5'd9, 64'h0,    64'h99,   2'b10});
        vecs.push_back('{2'b11, 5'd1, 5'd2, 64'h1111, 64'h2222, 2'b01});
        vecs.push_back('{2'b11, 5'd1, 5'd2, 64'h1111, 64'h2222, 2'b10});
        vecs.push_back('{2'b11, 5'd1, 5'd2, 64'h1111, 64'h2222, 2'b01});
        vecs.push_back('{2'b11, 5'd1, 5'd2, 64'h1111, 64'h2222, 2'b10});
        vecs.push_back('{2'b10, 5'd0, 5'd3, 64'h0,    64'h3030, 2'b10});
        vecs.push_back('{2'b11, 5'd4, 5'd8, 64'h4040, 64'h8080, 2'b01});
        vecs.push_back('{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    2'b00});
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].rd0, vecs[i].rd1, vecs[i].d0, vecs[i].d1);
            cycle($sformatf("vec%0d", i), vecs[i].exp_ready, 1'b0, 1'b0, 1'b0);
        end

        // Scoreboard: claim x7, re-claim refused, LSU writeback clears it on the commit edge
        drive(2'b00, '0, '0, '0, '0);
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd0;
        cycle("sb_claim", 2'b00, 1'b1, 1'b0, 1'b0);
        cycle("sb_reclaim", 2'b00, 1'b0, 1'b1, 1'b0);
        issue_valid = 1'b0;
        drive(2'b10, 5'd0, 5'd7, 64'h0, 64'h77);
        cycle("sb_wb", 2'b10, 1'b0, 1'b1, 1'b0);
        drive(2'b00, '0, '0, '0, '0);
        cycle("sb_commit", 2'b00, 1'b0, 1'b1, 1'b0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle("sb_reissue", 2'b00, 1'b1, 1'b0, 1'b0);
        issue_valid = 1'b0;

        // x0: claim accepted without setting busy, writeback handshakes but never writes
        issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
        cycle("x0_claim", 2'b00, 1'b1, 1'b0, 1'b0);
        issue_valid = 1'b0;
        drive(2'b01, 5'd0, 5'd0, 64'hABC, 64'h0);
        cycle("x0_wb", 2'b01, 1'b0, 1'b0, 1'b0);
        drive(2'b00, '0, '0, '0, '0);
        cycle("x0_after", 2'b00, 1'b0, 1'b0, 1'b0);

        // flush with x3/x9 busy, same-cycle claim of x4 and a write to x3 in flight
        rs1 = 5'd3; rs2 = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd3;
        cycle("fl_claim3", 2'b00, 1'b1, 1'b0, 1'b0);
        issue_rd = 5'd9;
        cycle("fl_claim9", 2'b00, 1'b1, 1'b1, 1'b0);
        issue_valid = 1'b0;
        cycle("fl_busy", 2'b00, 1'b0, 1'b1, 1'b1);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
        drive(2'b01, 5'd3, 5'd0, 64'h3333, 64'h0);
        cycle("fl_flush", 2'b01, 1'b1, 1'b1, 1'b1);
        flush = 1'b0; issue_valid = 1'b0;
        drive(2'b00, '0, '0, '0, '0);
        rs1 = 5'd3; rs2 = 5'd4;
        cycle("fl_after34", 2'b00, 1'b0, 1'b0, 1'b0);
        rs1 = 5'd9;
        cycle("fl_after9", 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset mid-write: rf_we drops at once and the scoreboard empties
        issue_valid = 1'b1; issue_rd = 5'd6; rs1 = 5'd6; rs2 = 5'd0;
        cycle("rst_claim", 2'b00, 1'b1, 1'b0, 1'b0);
        issue_valid = 1'b0;
        drive(2'b01, 5'd6, 5'd0, 64'h6666, 64'h0);
        cycle("rst_wb", 2'b01, 1'b0, 1'b1, 1'b0);
        drive(2'b00, '0, '0, '0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid rf_we",    XLEN'(rf_we),    '0);
        chk("rst_mid rf_waddr", XLEN'(rf_waddr), '0);
        chk("rst_mid rf_wdata", rf_wdata,        '0);
        issue_valid = 1'b1; issue_rd = 5'd6;
        #1;
        chk("rst_mid issue_ready x6", XLEN'(issue_ready), 64'd1);
        chk("rst_mid rs1_busy x6",    XLEN'(rs1_busy),    '0);
        issue_rd = 5'd7;
        #1;
        chk("rst_mid issue_ready x7", XLEN'(issue_ready), 64'd1);
        issue_valid = 1'b0;
        m_addr = '0;
        m_data = '0;
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Arbitration history restarts: ALU wins the first tie again
        drive(2'b11, 5'd1, 5'd2, 64'hA, 64'hB);
        cycle("post_rst0", 2'b01, 1'b0, 1'b0, 1'b0);
        cycle("post_rst1", 2'b10, 1'b0, 1'b0, 1'b0);
        drive(2'b00, '0, '0, '0, '0);
        cycle("post_rst2", 2'b00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
